// File: rtl/stages_definition_pkg.sv
// Shared pipeline definitions for the pixel write buffer: screen geometry
// defaults, the buffered write request record and the buffer FSM states.
package stages_definition_pkg;

  localparam int PIX_SCREEN_W = 640;
  localparam int PIX_SCREEN_H = 480;
  localparam int PIX_ADDR_W   = 19;
  localparam int PIX_PIX_W    = 8;

  // One buffered pixel write: linear frame address plus the stored pixel.
  typedef struct packed {
    bit [PIX_ADDR_W-1:0] addr;
    bit [PIX_PIX_W-1:0]  pix;
  } pix_req;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    RD_WAIT_DRAIN,
    RD_REQ,
    RD_RESP
  } pix_buf_state;

endpackage

// File: rtl/pix_write_buffer_fifo.sv
// pix_fifo: small synchronous FIFO with occupancy count.
// Push while full and pop while empty are ignored.
module pix_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pix_write_buffer.sv
// pix_write_buffer: MEM-stage pixel memory responder. Writes are queued and
// drained to the single-port frame memory; reads wait for all older writes.
// Optional build macro PIX_BUF_CLIP_EN: drop off-screen writes, answer
// off-screen reads with zero, and expose a sticky clip_err flag.
module pix_write_buffer
  import stages_definition_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int SCREEN_W = PIX_SCREEN_W,
  parameter int SCREEN_H = PIX_SCREEN_H,
  parameter int ADDR_W   = PIX_ADDR_W,
  parameter int PIX_W    = PIX_PIX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [31:0]       ax,
  input  logic [31:0]       ay,
  input  logic [31:0]       wd,
  input  logic              rd_en,
  input  logic [31:0]       rd_ax,
  input  logic [31:0]       rd_ay,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              stall_o,
  output logic              pm_valid,
  input  logic              pm_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [PIX_W-1:0]  pm_wdata,
  input  logic              pm_rvalid,
  input  logic [PIX_W-1:0]  pm_rdata
`ifdef PIX_BUF_CLIP_EN
  ,
  output logic              clip_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + PIX_W;

  pix_buf_state      state_q, state_d;
  logic [CW-1:0]     drain_q, drain_d;   // writes still ahead of the pending read
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q;
  logic [31:0]       rd_data_q;

  logic [31:0]       wr_lin, rd_lin;
  logic              wr_in, rd_in;
  logic              push, pop, full, empty, rd_acc, wr_phase, rd_pend;
  logic [CW-1:0]     count, cnt_after;
  logic [EW-1:0]     head;

  // Linear frame address from the low 16 bits of each coordinate.
  assign wr_lin = ({16'd0, ay[15:0]} * 32'(SCREEN_W)) + {16'd0, ax[15:0]};
  assign rd_lin = ({16'd0, rd_ay[15:0]} * 32'(SCREEN_W)) + {16'd0, rd_ax[15:0]};

`ifdef PIX_BUF_CLIP_EN
  logic clip_err_q;
  assign wr_in    = (ax < 32'(SCREEN_W)) && (ay < 32'(SCREEN_H));
  assign rd_in    = (rd_ax < 32'(SCREEN_W)) && (rd_ay < 32'(SCREEN_H));
  assign clip_err = clip_err_q;

  // Sticky record of any off-screen access that was dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_err_q <= 1'b0;
    else if ((wr_en && !wr_in) || (rd_acc && !rd_in)) clip_err_q <= 1'b1;
  end

  logic unused_bits;
  assign unused_bits = ^{wd[31:PIX_W]};
`else
  assign wr_in = 1'b1;
  assign rd_in = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{ax[31:16], ay[31:16], rd_ax[31:16], rd_ay[31:16],
                         wd[31:PIX_W], 32'(SCREEN_H)};
`endif

  // Space freed by a same-cycle pop is not reused; stall depends on count only.
  assign push = wr_en && wr_in && !full;

  pix_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({wr_lin[ADDR_W-1:0], wd[PIX_W-1:0]}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // A read is taken only when no other read is outstanding, the same-cycle
  // write (older in program order) is not being refused, and the previous
  // read's completion pulse is not on the bus (that instruction is leaving).
  assign rd_acc   = rd_en && !full && !rd_valid_q &&
                    ((state_q == IDLE) || (state_q == WR_REQ));
  assign rd_pend  = (state_q == RD_WAIT_DRAIN) || (state_q == RD_REQ) ||
                    (state_q == RD_RESP);
  assign wr_phase = (state_q == WR_REQ) ||
                    ((state_q == RD_WAIT_DRAIN) && (drain_q != '0));
  assign pop      = wr_phase && pm_ready;
  assign cnt_after = count + CW'(push) - CW'(pop);

  assign stall_o  = full || rd_acc || rd_pend;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

  // Memory request port: head of FIFO while draining, latched read address.
  always_comb begin
    pm_valid = 1'b0;
    pm_we    = 1'b0;
    pm_addr  = '0;
    pm_wdata = '0;
    if (wr_phase) begin
      pm_valid = 1'b1;
      pm_we    = 1'b1;
      pm_addr  = head[EW-1:PIX_W];
      pm_wdata = head[PIX_W-1:0];
    end else if (state_q == RD_REQ) begin
      pm_valid = 1'b1;
      pm_addr  = rd_addr_q;
    end
  end

  // Next-state: drain writes, then issue the read once older writes are gone.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:    if (push || !empty) state_d = WR_REQ;
      WR_REQ:  if (pop && (cnt_after == '0)) state_d = IDLE;
      RD_WAIT_DRAIN: begin
        if (pop) drain_d = drain_q - 1'b1;
        if ((drain_q == '0) || (pop && (drain_q == CW'(1)))) state_d = RD_REQ;
      end
      RD_REQ:  if (pm_ready) state_d = RD_RESP;
      RD_RESP: if (pm_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_acc && rd_in) begin
      state_d = RD_WAIT_DRAIN;
      drain_d = cnt_after;
    end
  end

  // FSM state, pending-read bookkeeping and the read return register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      rd_valid_q <= 1'b0;
      if (rd_acc) rd_addr_q <= rd_lin[ADDR_W-1:0];
      if ((state_q == RD_RESP) && pm_rvalid) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= {{(32-PIX_W){1'b0}}, pm_rdata};
      end else if (rd_acc && !rd_in) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pix_write_buffer.sv
// Directed bench for pix_write_buffer. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_pix_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en, pm_ready, pm_rvalid;
  logic [31:0] ax, ay, wd, rd_ax, rd_ay;
  logic [7:0]  pm_rdata;
  logic [31:0] rd_data;
  logic        rd_valid, stall_o, pm_valid, pm_we;
  logic [18:0] pm_addr;
  logic [7:0]  pm_wdata;
`ifdef PIX_BUF_CLIP_EN
  logic        clip_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pix_write_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .ax(ax), .ay(ay), .wd(wd),
    .rd_en(rd_en), .rd_ax(rd_ax), .rd_ay(rd_ay),
    .rd_data(rd_data), .rd_valid(rd_valid), .stall_o(stall_o),
    .pm_valid(pm_valid), .pm_ready(pm_ready), .pm_we(pm_we),
    .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .pm_rvalid(pm_rvalid), .pm_rdata(pm_rdata)
`ifdef PIX_BUF_CLIP_EN
    , .clip_err(clip_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pm_valid"}, 32'(pm_valid), 0);
    chk({tag, "_pm_we"},    32'(pm_we),    0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_stall"},    32'(stall_o),  0);
    chk({tag, "_pm_addr"},  32'(pm_addr),  0);
    chk({tag, "_pm_wdata"}, 32'(pm_wdata), 0);
    chk({tag, "_rd_data"},  rd_data,       0);
  endtask

  initial begin
    rst_n = 0; wr_en = 0; rd_en = 0; pm_ready = 0; pm_rvalid = 0;
    ax = 0; ay = 0; wd = 0; rd_ax = 0; rd_ay = 0; pm_rdata = 0;
    #12;
    chk_idle_outputs("reset");
    nx(); rst_n = 1;

    // Single write (3,2) -> address 2*640+3 = 1283, pixel 0xAB
    nx(); wr_en = 1; ax = 3; ay = 2; wd = 32'h1AB; pm_ready = 1;
    nx(); wr_en = 0; #1;
    chk("w1_valid", 32'(pm_valid), 1);
    chk("w1_we",    32'(pm_we),    1);
    chk("w1_addr",  32'(pm_addr),  1283);
    chk("w1_data",  32'(pm_wdata), 32'hAB);
    chk("w1_stall", 32'(stall_o),  0);
    nx(); #1;
    chk("w1_done",  32'(pm_valid), 0);

    // Five writes with memory not ready: four queue, fifth stalls
    pm_ready = 0;
    for (int i = 0; i < 4; i++) begin
      nx(); wr_en = 1; ax = i; ay = 0; wd = 32'h10 + i;
    end
    nx(); ax = 4; wd = 32'h14; #1;
    chk("full_stall", 32'(stall_o),  1);
    chk("full_addr",  32'(pm_addr),  0);
    chk("full_data",  32'(pm_wdata), 32'h10);
    pm_ready = 1;
    nx(); #1;
    chk("drain1_stall", 32'(stall_o),  0);
    chk("drain1_addr",  32'(pm_addr),  1);
    chk("drain1_data",  32'(pm_wdata), 32'h11);
    nx(); wr_en = 0; #1;
    chk("drain2_addr",  32'(pm_addr),  2);
    nx(); #1;
    chk("drain3_addr",  32'(pm_addr),  3);
    nx(); #1;
    chk("drain4_valid", 32'(pm_valid), 1);
    chk("drain4_addr",  32'(pm_addr),  4);
    chk("drain4_data",  32'(pm_wdata), 32'h14);
    nx(); #1;
    chk("drain_done",   32'(pm_valid), 0);

    // Same-cycle write (10,0,0x55) and read (10,0): write goes out first
    nx(); wr_en = 1; ax = 10; ay = 0; wd = 32'h55;
    rd_en = 1; rd_ax = 10; rd_ay = 0; #1;
    chk("raw_acc_stall", 32'(stall_o), 1);
    nx(); wr_en = 0; #1;
    chk("raw_wr_valid", 32'(pm_valid), 1);
    chk("raw_wr_we",    32'(pm_we),    1);
    chk("raw_wr_addr",  32'(pm_addr),  10);
    chk("raw_wr_data",  32'(pm_wdata), 32'h55);
    chk("raw_wr_stall", 32'(stall_o),  1);
    nx(); #1;
    chk("raw_rd_valid", 32'(pm_valid), 1);
    chk("raw_rd_we",    32'(pm_we),    0);
    chk("raw_rd_addr",  32'(pm_addr),  10);
    nx(); #1;
    chk("raw_resp_idle",  32'(pm_valid), 0);
    chk("raw_resp_stall", 32'(stall_o),  1);
    pm_rvalid = 1; pm_rdata = 8'h55;
    nx(); #1;
    chk("raw_rvalid", 32'(rd_valid), 1);
    chk("raw_rdata",  rd_data,       32'h55);
    chk("raw_stall",  32'(stall_o),  0);
    pm_rvalid = 0; rd_en = 0;
    nx(); #1;
    chk("raw_pulse", 32'(rd_valid), 0);

    // Read (5,1) = 645 with the response three cycles late
    nx(); rd_en = 1; rd_ax = 5; rd_ay = 1;
    nx(); nx(); #1;
    chk("dly_req_valid", 32'(pm_valid), 1);
    chk("dly_req_we",    32'(pm_we),    0);
    chk("dly_req_addr",  32'(pm_addr),  645);
    for (int i = 0; i < 3; i++) begin
      nx(); #1;
      chk("dly_wait_valid", 32'(pm_valid), 0);
      chk("dly_wait_rv",    32'(rd_valid), 0);
      chk("dly_wait_stall", 32'(stall_o),  1);
    end
    pm_rvalid = 1; pm_rdata = 8'h3C;
    nx(); #1;
    chk("dly_rvalid", 32'(rd_valid), 1);
    chk("dly_rdata",  rd_data,       32'h3C);
    pm_rvalid = 0; rd_en = 0;
    nx(); #1;
    chk("dly_pulse", 32'(rd_valid), 0);
    pm_rvalid = 1; pm_rdata = 8'hFF;
    nx(); pm_rvalid = 0; #1;
    chk("stray_rv",    32'(rd_valid), 0);
    chk("stray_valid", 32'(pm_valid), 0);

    // Asynchronous reset with three writes queued and a request on the bus
    pm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      nx(); wr_en = 1; ax = 7 + i; ay = 1; wd = 32'hA0 + i;
    end
    nx(); wr_en = 0; #1;
    chk("pre_rst_valid", 32'(pm_valid), 1);
    chk("pre_rst_addr",  32'(pm_addr),  647);
    #1 rst_n = 0; #1;
    chk_idle_outputs("async_rst");
    nx(); rst_n = 1; pm_ready = 1;
    for (int i = 0; i < 3; i++) begin
      nx(); #1;
      chk("post_rst_valid", 32'(pm_valid), 0);
    end

`ifdef PIX_BUF_CLIP_EN
    // Off-screen write is dropped; off-screen read answers zero directly
    nx(); wr_en = 1; ax = 640; ay = 0; wd = 32'h77;
    nx(); wr_en = 0; #1;
    chk("clip_w_valid", 32'(pm_valid), 0);
    chk("clip_err_set", 32'(clip_err), 1);
    nx(); #1;
    chk("clip_err_hold", 32'(clip_err), 1);
    chk("clip_w_none",   32'(pm_valid), 0);
    nx(); rd_en = 1; rd_ax = 0; rd_ay = 480; #1;
    chk("clip_r_stall", 32'(stall_o), 1);
    nx(); #1;
    chk("clip_r_rv",    32'(rd_valid), 1);
    chk("clip_r_data",  rd_data,       0);
    chk("clip_r_nomem", 32'(pm_valid), 0);
    rd_en = 0;
`endif

    nx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pix_write_buffer.md
Name: pix_write_buffer

Overview:
- Responder end of the MEM-stage pixel-memory interface: receives MEM-stage pixel writes (Ax, Ay, WD, memPixWrite) and pixel reads that return into the pixMemRead field of mem_wb_interface.
- Buffers writes in a small FIFO and drains them to the single-port pixel frame memory over a valid/ready handshake.
- Services reads in program order, after all earlier writes.
- Raises a stall toward the hazard unit when it cannot accept a request.

Parameters:
- DEPTH, 4, write FIFO entries (power of two, >=2)
- SCREEN_W, 640, pixels per row
- SCREEN_H, 480, rows
- ADDR_W, 19, pixel memory address width
- PIX_W, 8, stored pixel width; the low PIX_W bits of WD are written

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  MEM-stage memPixWrite
- ax  in  32  write X coordinate (exe_mem Ax)
- ay  in  32  write Y coordinate (exe_mem Ay)
- wd  in  32  write data (exe_mem WD)
- rd_en  in  1  MEM-stage pixel read request
- rd_ax  in  32  read X coordinate
- rd_ay  in  32  read Y coordinate
- rd_data  out  32  zero-extended pixel, feeds mem_wb pixMemRead
- rd_valid  out  1  one-cycle pulse, rd_data valid
- stall_o  out  1  to hazard unit; holds the MEM stage
- pm_valid  out  1  memory request valid
- pm_ready  in  1  memory accepts request
- pm_we  out  1  1 = write, 0 = read
- pm_addr  out  ADDR_W  ay*SCREEN_W+ax, truncated to ADDR_W
- pm_wdata  out  PIX_W  write pixel
- pm_rvalid  in  1  read data return
- pm_rdata  in  PIX_W  read pixel

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - FIFO empty, count 0, state IDLE.
  - pm_valid, pm_we, rd_valid, stall_o = 0.
  - pm_addr, pm_wdata, rd_data = 0.
- Address arithmetic:
  - Computed at enqueue as ay[15:0]*SCREEN_W + ax[15:0], truncated to ADDR_W.
  - The FIFO stores {addr, pix}.
- Enqueue:
  - wr_en and count<DEPTH pushes on the rising edge.
  - wr_en and count==DEPTH does not push; stall_o=1 combinationally, and upstream holds wr_en until accepted.
  - A pop in the same cycle does not free space for that cycle's push (stall_o depends on count only).
- FSM states: IDLE, WR_REQ, RD_WAIT_DRAIN, RD_REQ, RD_RESP.
  - IDLE: FIFO non-empty -> WR_REQ. rd_en -> RD_WAIT_DRAIN, with rd_ax/rd_ay latched.
  - WR_REQ: pm_valid=1, pm_we=1, head entry on pm_addr/pm_wdata. pm_valid&pm_ready pops; go to IDLE, or stay in WR_REQ if the FIFO is still non-empty. pm_* stays stable while ready is low.
  - RD_WAIT_DRAIN: drains writes exactly as in WR_REQ. FIFO empty and no request in flight -> RD_REQ.
  - RD_REQ: pm_valid=1, pm_we=0, latched read address. Handshake -> RD_RESP.
  - RD_RESP: wait for pm_rvalid. rd_data={0,pm_rdata}, rd_valid=1 for one cycle -> IDLE.
- stall_o = full, or rd_en accepted and read not yet returned. stall_o drops in the cycle rd_valid pulses.
- Ordering and simultaneous events:
  - wr_en and rd_en in the same cycle: the write is enqueued first, and the read observes it (RAW-safe).
  - A wr_en arriving while a read is pending is enqueued (space permitting) and drains after the read returns.
- One memory request outstanding at most. pm_rvalid outside RD_RESP is ignored.
- Reset mid-transaction: FIFO contents and the pending read are discarded, outputs return to reset values, and any in-flight memory response is ignored.

Optional Feature:
- Macro: PIX_BUF_CLIP_EN.
- Defined:
  - Writes with ax>=SCREEN_W or ay>=SCREEN_H are dropped at enqueue (no push, no stall).
  - Out-of-range reads return rd_data=0 without a memory access, rd_valid one cycle after the request.
  - Extra output port clip_err (1 bit): sticky flag, set on any drop, cleared only by reset.
- Undefined: no range check, address is truncated, port clip_err absent.

Decomposition:
- Add to stages_definition_pkg:
  - pix_req struct {bit [ADDR_W-1:0] addr; bit [PIX_W-1:0] pix;}
  - pix_buf_state enum for the FSM
  - constants SCREEN_W / SCREEN_H defaults
- Sub-module pix_fifo: parameterised synchronous FIFO with push/pop/full/empty/count, asynchronous active-low reset.
- pix_write_buffer contains the address computation, FSM and stall logic.

Test Plan:
- Single write ax=3, ay=2, wd=0x1AB, pm_ready=1 -> next cycle pm_valid=1, pm_we=1, pm_addr=1283, pm_wdata=0xAB; FIFO empty after the handshake.
- pm_ready=0, five consecutive writes -> 4 accepted, stall_o=1 on the 5th. Raise ready -> drains in FIFO order and the 5th is accepted once count<4.
- Write (10,0,0x55) and read (10,0) in the same cycle, memory returns 0x55 -> write handshake precedes the read request, rd_data=0x55, stall_o high until the rd_valid cycle.
- Read with pm_rvalid delayed 3 cycles -> rd_valid single pulse, pm_valid low during wait; stray pm_rvalid in IDLE has no effect.
- rst_n low while the FIFO holds 3 entries and pm_valid=1 -> all outputs 0 immediately (asynchronous); after release, no residual writes issued.
- PIX_BUF_CLIP_EN defined: write ax=640, ay=0 -> no pm_valid, clip_err=1 and stays 1; read (0,480) -> rd_data=0 next cycle.
